// File: rtl/avg_pkg.sv
// avg_pkg: shared types, default sizes and the mean helper for avg_window_accum.
//   avg_state_t     : two-state window FSM (ACCUM collects samples, HOLD presents the mean)
//   AVG_DATA_W      : default sample / mean width
//   AVG_WIN_LOG2    : default log2 of the window length
//   avg_shift_mean  : divides a window total by 2**win_log2
// Configuration macro: AVG_WINDOW_ROUND_EN selects round-half-up instead of floor.
package avg_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } avg_state_t;

    localparam int AVG_DATA_W    = 8;
    localparam int AVG_WIN_LOG2  = 2;
    // Working width of the helper; wide enough for any legal DATA_W/WIN_LOG2 total.
    localparam int AVG_MAX_SUM_W = 32;

    function automatic logic [AVG_MAX_SUM_W-1:0] avg_shift_mean(
        input logic [AVG_MAX_SUM_W-1:0] sum,
        input int unsigned              win_log2
    );
        logic [AVG_MAX_SUM_W-1:0] w_total;
        w_total = sum;
`ifdef AVG_WINDOW_ROUND_EN
        // Adding half an LSB of the result before the shift gives round-half-up.
        w_total = sum + (AVG_MAX_SUM_W'(1) << (win_log2 - 1));
`endif
        return w_total >> win_log2;
    endfunction

endpackage

// File: rtl/avg_window_accum.sv
// avg_window_accum: accumulates 2**WIN_LOG2 samples and emits their mean.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : upstream sample valid
//   in_ready  : block accepts a sample this cycle (ACCUM and no clear)
//   in_data   : sample
//   clear     : synchronous discard of the partial window (ignored in HOLD)
//   out_valid : windowed mean available
//   out_ready : downstream accepts mean
//   out_data  : windowed mean, stable while out_valid is high
//   fill      : samples accumulated in the current window (0..N-1)
// Configuration macro: AVG_WINDOW_ROUND_EN (round-half-up mean; floor otherwise).
module avg_window_accum
    import avg_pkg::*;
#(
    parameter int DATA_W   = AVG_DATA_W,
    parameter int WIN_LOG2 = AVG_WIN_LOG2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                clear,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [WIN_LOG2:0]   fill
);

    localparam int SUM_W  = DATA_W + WIN_LOG2;
    localparam int FILL_W = WIN_LOG2 + 1;
    localparam int N      = 1 << WIN_LOG2;

    avg_state_t          r_state;
    avg_state_t          w_state_nxt;
    logic [SUM_W-1:0]    r_sum;
    logic [FILL_W-1:0]   r_fill;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;

    logic                w_accept;
    logic                w_last;
    logic [SUM_W-1:0]    w_sum_total;

    assign w_accept    = in_valid && in_ready;
    assign w_last      = (r_fill == FILL_W'(N - 1));
    assign w_sum_total = r_sum + {{WIN_LOG2{1'b0}}, in_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        unique case (r_state)
            ACCUM: begin
                in_ready = !clear;
                if (in_valid && !clear && w_last) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum       <= '0;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            unique case (r_state)
                ACCUM: begin
                    if (clear) begin
                        r_sum  <= '0;
                        r_fill <= '0;
                    end else if (w_accept) begin
                        if (w_last) begin
                            // Window complete: the mean uses the total including this sample.
                            r_sum       <= '0;
                            r_fill      <= '0;
                            r_out_valid <= 1'b1;
                            r_out_data  <= DATA_W'(avg_shift_mean(
                                AVG_MAX_SUM_W'(w_sum_total), WIN_LOG2));
                        end else begin
                            r_sum  <= w_sum_total;
                            r_fill <= r_fill + FILL_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign fill      = r_fill;

endmodule

// File: tb/tb_avg_window_accum.sv
module tb_avg_window_accum;
    import avg_pkg::*;

    localparam int N = 4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       clear;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] fill;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference: the current partial window as a list of samples, plus the pending mean.
    int win[$];
    bit m_pending;
    int m_mean;

    avg_window_accum #(.DATA_W(8), .WIN_LOG2(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .fill      (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int window_mean(input int s[$]);
        int total = 0;
        foreach (s[i]) total += s[i];
`ifdef AVG_WINDOW_ROUND_EN
        total += N / 2;
`endif
        return total / N;
    endfunction

    task automatic model_reset();
        win.delete();
        m_pending = 1'b0;
        m_mean    = 0;
    endtask

    task automatic model_step(input bit v, input int d, input bit c, input bit ordy);
        if (m_pending) begin
            if (ordy) m_pending = 1'b0;
        end else if (c) begin
            win.delete();
        end else if (v) begin
            win.push_back(d);
            if (win.size() == N) begin
                m_mean    = window_mean(win);
                m_pending = 1'b1;
                win.delete();
            end
        end
    endtask

    task automatic check_outputs();
        check("out_valid", out_valid, m_pending);
        check("fill", fill, win.size());
        if (m_pending) check("out_data", out_data, m_mean);
    endtask

    // Called at posedge+1; returns at the next posedge+1 with outputs checked.
    task automatic cycle(input bit v, input logic [7:0] d, input bit c, input bit ordy);
        in_valid  = v;
        in_data   = d;
        clear     = c;
        out_ready = ordy;
        #1;
        check("in_ready", in_ready, !m_pending && !c);
        @(posedge clk);
        model_step(v, int'(d), c, ordy);
        #1;
        check_outputs();
    endtask

    task automatic feed(input logic [7:0] d, input bit ordy);
        cycle(1'b1, d, 1'b0, ordy);
    endtask

    initial begin
        int exp_basic;
        int exp_bp;
        logic [7:0] held;
`ifdef AVG_WINDOW_ROUND_EN
        exp_basic = 5;
        exp_bp    = 15;
`else
        exp_basic = 4;
        exp_bp    = 14;
`endif
        rst = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_fill", fill, 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Basic window 3,4,5,6.
        feed(8'd3, 1'b1); feed(8'd4, 1'b1); feed(8'd5, 1'b1); feed(8'd6, 1'b1);
        check("basic_mean", out_data, exp_basic);
        check("basic_valid", out_valid, 1);
        cycle(1'b0, 8'd0, 1'b0, 1'b1);
        #1;
        check("basic_ready_after", in_ready, 1);

        // Max values.
        repeat (N) feed(8'd255, 1'b1);
        check("max_mean", out_data, 255);
        cycle(1'b0, 8'd0, 1'b0, 1'b1);

        // Backpressure with a sample presented while holding.
        feed(8'd15, 1'b0); feed(8'd15, 1'b0); feed(8'd15, 1'b0); feed(8'd14, 1'b0);
        check("bp_mean", out_data, exp_bp);
        repeat (5) cycle(1'b1, 8'd99, 1'b0, 1'b0);
        check("bp_hold_data", out_data, exp_bp);
        cycle(1'b1, 8'd99, 1'b0, 1'b1);
        check("bp_fill_after", fill, 0);

        // Clear drops a partial window and the sample offered alongside it.
        feed(8'd10, 1'b1); feed(8'd12, 1'b1);
        cycle(1'b1, 8'd7, 1'b1, 1'b1);
        check("clear_fill", fill, 0);
        repeat (N) feed(8'd2, 1'b1);
        check("clear_mean", out_data, 2);
        cycle(1'b0, 8'd0, 1'b0, 1'b1);

        // Clear while holding is ignored.
        feed(8'd1, 1'b0); feed(8'd2, 1'b0); feed(8'd3, 1'b0); feed(8'd8, 1'b0);
        held = out_data;
        repeat (3) cycle(1'b0, 8'd0, 1'b1, 1'b0);
        check("hold_clear_data", out_data, held);
        check("hold_clear_valid", out_valid, 1);
        cycle(1'b0, 8'd0, 1'b1, 1'b1);

        // Asynchronous reset mid-window, then a fresh window.
        feed(8'd200, 1'b1); feed(8'd100, 1'b1);
        #3 rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_fill", fill, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        feed(8'd8, 1'b1); feed(8'd9, 1'b1); feed(8'd10, 1'b1); feed(8'd11, 1'b1);
        check("arst_new_mean", out_data, window_mean('{8, 9, 10, 11}));

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), 8'($urandom),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
